// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared state and control-mux encodings for the hazard controller
package hazard_ctrl_unit_pkg;
  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FREEZE       = 2'd1,
    FREEZE_REDIR = 2'd2
  } state_e;
  localparam logic CTRL_PASS   = 1'b1;
  localparam logic CTRL_BUBBLE = 1'b0;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-side hazard inputs and stall/flush controls
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] if_id_rs, if_id_rt, id_ex_rt;
  logic                  id_uses_rt, id_ex_mem_read, jump_id, branch_taken_mem, mem_busy;
  logic                  pc_write, redirect_valid, if_id_write, if_id_flush;
  logic                  ctrl_select, id_ex_write, ex_mem_flush, pipe_hold;
  logic [CNT_W-1:0]      stall_cycles;
  modport slave (
    input  if_id_rs, if_id_rt, id_uses_rt, id_ex_rt, id_ex_mem_read, jump_id, branch_taken_mem, mem_busy,
    output pc_write, redirect_valid, if_id_write, if_id_flush, ctrl_select, id_ex_write, ex_mem_flush,
           pipe_hold, stall_cycles
  );
  modport master (
    output if_id_rs, if_id_rt, id_uses_rt, id_ex_rt, id_ex_mem_read, jump_id, branch_taken_mem, mem_busy,
    input  pc_write, redirect_valid, if_id_write, if_id_flush, ctrl_select, id_ex_write, ex_mem_flush,
           pipe_hold, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// hazard_ctrl_unit_sat_counter: enable-driven up counter that sticks at all-ones
module hazard_ctrl_unit_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign cnt_d = (en_i && !(&cnt_q)) ? cnt_q + WIDTH'(1) : cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use/jump/branch/memory-busy stall and flush controller for the 5-stage core
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              arst_n,
  hazard_ctrl_unit_if.slave hz
);
  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  load_use, redirect;
  logic                  pc_w, redir_v, ifid_w, ifid_f, sel, idex_w, exmem_f, hold;
  assign ex_rt    = hz.id_ex_rt;
  assign load_use = hz.id_ex_mem_read && (ex_rt != '0) &&
                    (ex_rt == hz.if_id_rs || (hz.id_uses_rt && ex_rt == hz.if_id_rt));
  assign redirect = (state_q == FREEZE_REDIR) || hz.branch_taken_mem;
  always_comb begin
    pc_w    = 1'b1;
    redir_v = 1'b0;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    sel     = CTRL_PASS;
    idex_w  = 1'b1;
    exmem_f = 1'b0;
    hold    = 1'b0;
    state_d = RUN;
    if (hz.mem_busy) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      hold    = 1'b1;
      state_d = redirect ? FREEZE_REDIR : FREEZE;
    end else if (redirect) begin
      redir_v = 1'b1;
      ifid_f  = 1'b1;
      sel     = CTRL_BUBBLE;
      exmem_f = 1'b1;
    end else if (load_use) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      sel     = CTRL_BUBBLE;
    end else if (hz.jump_id) begin
      ifid_f  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state_q <= RUN;
    else         state_q <= state_d;
  // every enable/flush is forced low for as long as reset is held
  assign hz.pc_write       = arst_n & pc_w;
  assign hz.redirect_valid = arst_n & redir_v;
  assign hz.if_id_write    = arst_n & ifid_w;
  assign hz.if_id_flush    = arst_n & ifid_f;
  assign hz.ctrl_select    = arst_n ? sel : CTRL_BUBBLE;
  assign hz.id_ex_write    = arst_n & idex_w;
  assign hz.ex_mem_flush   = arst_n & exmem_f;
  assign hz.pipe_hold      = arst_n & hold;
  hazard_ctrl_unit_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .en_i   (!hz.pc_write),
    .cnt_o  (hz.stall_cycles)
  );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: table-driven vectors plus freeze/reset/saturation sequences
module tb_hazard_ctrl_unit;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam logic [7:0] IDLE = 8'b1010_1100;
  localparam logic [7:0] LU   = 8'b0000_0100;
  localparam logic [7:0] JMP  = 8'b1011_1100;
  localparam logic [7:0] BR   = 8'b1111_0110;
  localparam logic [7:0] HOLD = 8'b0000_1001;
  localparam logic [7:0] RST  = 8'b0000_0000;
  typedef struct {
    string         name;
    logic [RW-1:0] rs, rt, ex_rt;
    logic          uses_rt, mem_read, jump, branch;
    logic [7:0]    exp;
  } vec_t;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  vec_t vecs[10];
  logic [7:0] obs;
  hazard_ctrl_unit_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hz ();
  hazard_ctrl_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (.clk(clk), .arst_n(arst_n), .hz(hz));
  always #5 clk = ~clk;
  assign obs = {hz.pc_write, hz.redirect_valid, hz.if_id_write, hz.if_id_flush,
                hz.ctrl_select, hz.id_ex_write, hz.ex_mem_flush, hz.pipe_hold};
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  task automatic set_in(input logic [RW-1:0] rs, rt, ex_rt, input logic uses_rt, mem_read, jump, branch, busy);
    hz.if_id_rs = rs; hz.if_id_rt = rt; hz.id_ex_rt = ex_rt; hz.id_uses_rt = uses_rt;
    hz.id_ex_mem_read = mem_read; hz.jump_id = jump; hz.branch_taken_mem = branch; hz.mem_busy = busy;
  endtask
  // entered at a negedge with inputs applied; leaves at the next negedge
  task automatic cycle(input string name, input logic [7:0] exp);
    #2 chk({name, " outs"}, {8'h0, obs}, {8'h0, exp});
    @(posedge clk);
    if (!exp[7] && exp_cnt < 15) exp_cnt++;
    #1 chk({name, " cnt"}, {12'h0, hz.stall_cycles}, 16'(exp_cnt));
    @(negedge clk);
  endtask
  task automatic rst_pulse(input string name);
    arst_n = 1'b0;
    exp_cnt = 0;
    #1 chk({name, " rst outs"}, {8'h0, obs}, {8'h0, RST});
    chk({name, " rst cnt"}, {12'h0, hz.stall_cycles}, 16'h0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask
  initial begin
    vecs[0] = '{"idle",        0, 0, 0, 0, 0, 0, 0, IDLE};
    vecs[1] = '{"lu_rs",       8, 0, 8, 0, 1, 0, 0, LU};
    vecs[2] = '{"lu_r0",       0, 0, 0, 1, 1, 0, 0, IDLE};
    vecs[3] = '{"lu_rs_rt0",   8, 0, 0, 0, 1, 0, 0, IDLE};
    vecs[4] = '{"lu_rt",       1, 5, 5, 1, 1, 0, 0, LU};
    vecs[5] = '{"rt_unused",   1, 5, 5, 0, 1, 0, 0, IDLE};
    vecs[6] = '{"no_load",     8, 8, 8, 1, 0, 0, 0, IDLE};
    vecs[7] = '{"jump_lu",     8, 0, 8, 0, 1, 1, 0, LU};
    vecs[8] = '{"jump",        8, 0, 8, 0, 0, 1, 0, JMP};
    vecs[9] = '{"branch_lu",   8, 8, 8, 1, 1, 1, 1, BR};
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("reset outs", {8'h0, obs}, {8'h0, RST});
    chk("reset cnt", {12'h0, hz.stall_cycles}, 16'h0);
    @(negedge clk);
    arst_n = 1'b1;
    foreach (vecs[i]) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].ex_rt, vecs[i].uses_rt, vecs[i].mem_read,
             vecs[i].jump, vecs[i].branch, 1'b0);
      cycle(vecs[i].name, vecs[i].exp);
    end
    rst_pulse("pre_freeze");
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cycle("busy_br1", HOLD);
    set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle("busy_br2", HOLD);
    cycle("busy_br3", HOLD);
    chk("freeze cnt3", {12'h0, hz.stall_cycles}, 16'd3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("late_redir", BR);
    cycle("after_redir", IDLE);
    set_in(0, 0, 0, 0, 0, 0, 0, 1); cycle("busy_plain", HOLD);
    set_in(0, 0, 0, 0, 0, 1, 0, 0); cycle("freeze_jump", JMP);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("freeze_done", IDLE);
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cycle("rst_fr_busy", HOLD);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #2 chk("fr_hold", {8'h0, obs}, {8'h0, HOLD});
    rst_pulse("mid_freeze");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("no_redir", IDLE);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle("sat", HOLD);
    chk("sat cnt15", {12'h0, hz.stall_cycles}, 16'd15);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("sat_release", IDLE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
